// File: rtl/alu_multicycle.sv
// Slice-sequential Y86-64 OPq unit (add/sub/and/xor), SLICE bits per clock, LSB first.
// Define ALU_CC_EN to build the ZF/SF/OF condition-code registers; otherwise flags read 0.
module alu_multicycle #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       fun,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             err,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       fun_q;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             accept, last, legal, is_sub, cin;
  logic [IdxW-1:0]  base;
  logic [SLICE-1:0] a_s, b_s, a_op, res_s;
  logic [SLICE:0]   sum_s;

  assign accept = (state_q == StIdle) && in_valid;
  assign last   = (cnt_q == CntW'(N - 1));
  assign legal  = (fun_q[3:2] == 2'b00);
  assign is_sub = (fun_q == 4'd1);

  // Slice datapath: one SLICE-wide adder/logic unit reused every RUN cycle.
  always_comb begin
    base  = IdxW'(32'(cnt_q) * SLICE);
    a_s   = a_q[base +: SLICE];
    b_s   = b_q[base +: SLICE];
    a_op  = is_sub ? ~a_s : a_s;
    // Subtract injects its +1 as carry-in of slice 0 only.
    cin   = carry_q | (is_sub && (cnt_q == '0));
    sum_s = {1'b0, b_s} + {1'b0, a_op} + {{SLICE{1'b0}}, cin};
    case (fun_q)
      4'd0, 4'd1: res_s = sum_s[SLICE-1:0];
      4'd2:       res_s = b_s & a_s;
      4'd3:       res_s = b_s ^ a_s;
      default:    res_s = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          carry_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        out_d[base +: SLICE] = res_s;
        carry_d              = sum_s[SLICE];
        cnt_d                = cnt_q + CntW'(1);
        if (last) begin
          state_d = StDone;
          err_d   = !legal;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Operand latches carry no reset: they are only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= A;
      b_q   <= B;
      fun_q <= fun;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Out       = out_q;
  assign err       = err_q;

`ifdef ALU_CC_EN
  logic setcc_q, zf_q, sf_q, of_q;
  logic ov;
  logic msb_a, msb_b, msb_r;

  assign msb_a = a_q[WIDTH-1];
  assign msb_b = b_q[WIDTH-1];
  assign msb_r = out_d[WIDTH-1];

  always_comb begin
    case (fun_q)
      4'd0:    ov = (msb_a == msb_b) && (msb_r != msb_a);
      4'd1:    ov = (msb_a != msb_b) && (msb_r != msb_b);
      default: ov = 1'b0;
    endcase
  end

  // Flags are taken from out_d so the final slice is included on the completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      setcc_q <= 1'b0;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      if (accept) begin
        setcc_q <= set_cc;
      end
      if ((state_q == StRun) && last && legal && setcc_q) begin
        zf_q <= (out_d == '0);
        sf_q <= msb_r;
        of_q <= ov;
      end
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`else
  logic unused_set_cc;
  assign unused_set_cc = set_cc;
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=64, SLICE=16) against a plain-arithmetic model.
module tb_alu_multicycle;

  localparam int W = 64;
  localparam int LAT = 4;
`ifdef ALU_CC_EN
  localparam bit CcEn = 1'b1;
`else
  localparam bit CcEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   fun;
  logic [W-1:0] A, B;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic         err;
  logic         zf, sf, of;

  int total = 0;
  int bad   = 0;

  // Architectural flag state as the model sees it.
  logic m_zf, m_sf, m_of;

  alu_multicycle #(.WIDTH(64), .SLICE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fun      (fun),
    .A        (A),
    .B        (B),
    .set_cc   (set_cc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out      (Out),
    .err      (err),
    .zf       (zf),
    .sf       (sf),
    .of       (of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sc;
  } op_t;

  function automatic logic [2:0] exp_flags();
    return CcEn ? {m_zf, m_sf, m_of} : 3'b000;
  endfunction

  // Reference: wide signed arithmetic for overflow, native operators for results.
  task automatic model_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sc, output logic [W-1:0] r, output logic e);
    logic [W:0] wide;
    logic       v;
    e = 1'b0;
    v = 1'b0;
    case (f)
      4'd0: begin
        wide = {b[W-1], b} + {a[W-1], a};
        r = b + a;
        v = wide[W] != wide[W-1];
      end
      4'd1: begin
        wide = {b[W-1], b} - {a[W-1], a};
        r = b - a;
        v = wide[W] != wide[W-1];
      end
      4'd2: r = b & a;
      4'd3: r = b ^ a;
      default: begin
        r = '0;
        e = 1'b1;
      end
    endcase
    if (sc && !e) begin
      m_zf = (r == '0);
      m_sf = r[W-1];
      m_of = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and wait (bounded) for out_valid; lat=-1 on timeout.
  task automatic run_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sc, output int lat);
    fun = f;
    A = a;
    B = b;
    set_cc = sc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_zf = 1'b1;
    m_sf = 1'b0;
    m_of = 1'b0;
    total++;
    if ({in_ready, out_valid, err} !== 3'b100) begin
      bad++;
      $display("FAIL reset_hs got=%b exp=100", {in_ready, out_valid, err});
    end
    total++;
    if (Out !== '0) begin
      bad++;
      $display("FAIL reset_out got=%h exp=0", Out);
    end
    total++;
    if ({zf, sf, of} !== exp_flags()) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=%b", {zf, sf, of}, exp_flags());
    end
  endtask

  task automatic test_directed();
    op_t          ops[10];
    logic [W-1:0] r;
    logic         e;
    int           lat;
    ops[0] = '{4'd0, 64'd4, 64'd3, 1'b1};
    ops[1] = '{4'd2, 64'd7, 64'd3, 1'b1};
    ops[2] = '{4'd3, 64'h7, 64'h7, 1'b1};
    ops[3] = '{4'd2, 64'hF0, 64'h0F, 1'b0};
    ops[4] = '{4'd1, 64'd4, 64'd3, 1'b1};
    ops[5] = '{4'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    ops[6] = '{4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    ops[7] = '{4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1};
    ops[8] = '{4'd9, 64'd5, 64'd6, 1'b1};
    ops[9] = '{4'd1, 64'h0001_0000, 64'h0000_FFFF, 1'b0};
    for (int i = 0; i < 10; i++) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_ready got=%b exp=1", i, in_ready);
      end
      run_op(ops[i].f, ops[i].a, ops[i].b, ops[i].sc, lat);
      model_op(ops[i].f, ops[i].a, ops[i].b, ops[i].sc, r, e);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT);
      end
      total++;
      if (Out !== r) begin
        bad++;
        $display("FAIL dir%0d_out got=%h exp=%h", i, Out, r);
      end
      total++;
      if (err !== e) begin
        bad++;
        $display("FAIL dir%0d_err got=%b exp=%b", i, err, e);
      end
      total++;
      if ({zf, sf, of} !== exp_flags()) begin
        bad++;
        $display("FAIL dir%0d_flags got=%b exp=%b", i, {zf, sf, of}, exp_flags());
      end
      release_result();
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
        bad++;
        $display("FAIL dir%0d_idle got=%b exp=10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, r;
    logic         e;
    int           lat;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run_op(4'd0, a, b, 1'b1, lat);
    model_op(4'd0, a, b, 1'b1, r, e);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      fun = 4'd1;
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      step();
      total++;
      if ({out_valid, in_ready, err} !== 3'b100 || Out !== r) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%h exp=100/%h", i, {out_valid, in_ready, err}, Out, r);
      end
    end
    in_valid = 1'b0;
    release_result();
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
        bad++;
        $display("FAIL bp_noaccept%0d got=%b exp=10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, r;
    logic         e;
    int           seen[$];
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    model_op(4'd1, a, b, 1'b0, r, e);
    fun = 4'd1;
    A = a;
    B = b;
    set_cc = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (out_valid) begin
        seen.push_back(k);
        total++;
        if (Out !== r) begin
          bad++;
          $display("FAIL b2b_out got=%h exp=%h", Out, r);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (seen.size() != 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=4", seen.size());
    end
    for (int i = 1; i < seen.size(); i++) begin
      total++;
      if (seen[i] - seen[i-1] != LAT + 2) begin
        bad++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", seen[i] - seen[i-1], LAT + 2);
      end
    end
    for (int k = 0; k < 10; k++) step();
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid, zf, sf, of} !== {2'b10, exp_flags()}) begin
      bad++;
      $display("FAIL b2b_drain got=%b exp=%b", {in_ready, out_valid, zf, sf, of},
               {2'b10, exp_flags()});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r;
    logic [3:0]   f;
    logic         sc, e;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 4));
      if (f == 4'd4) f = 4'($urandom_range(4, 15));
      sc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = 64'h7FFF_FFFF_FFFF_FFFF;
        1: a = 64'h8000_0000_0000_0000;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0: b = 64'hFFFF_FFFF_FFFF_FFFF;
        1: b = a;
        default: b = {$urandom, $urandom};
      endcase
      run_op(f, a, b, sc, lat);
      model_op(f, a, b, sc, r, e);
      repeat ($urandom_range(0, 3)) step();
      total++;
      if (lat !== LAT || Out !== r || err !== e || {zf, sf, of} !== exp_flags()) begin
        bad++;
        $display("FAIL rnd%0d f=%0d got=%0d/%h/%b/%b exp=%0d/%h/%b/%b", i, f, lat, Out, err,
                 {zf, sf, of}, LAT, r, e, exp_flags());
      end
      release_result();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r;
    logic         e;
    int           lat;
    run_op(4'd1, 64'd4, 64'd3, 1'b1, lat);
    model_op(4'd1, 64'd4, 64'd3, 1'b1, r, e);
    release_result();
    fun = 4'd0;
    A = 64'd10;
    B = 64'd20;
    set_cc = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_zf = 1'b1;
    m_sf = 1'b0;
    m_of = 1'b0;
    total++;
    if ({in_ready, out_valid, err} !== 3'b100 || Out !== '0) begin
      bad++;
      $display("FAIL midrst_state got=%b/%h exp=100/0", {in_ready, out_valid, err}, Out);
    end
    total++;
    if ({zf, sf, of} !== exp_flags()) begin
      bad++;
      $display("FAIL midrst_flags got=%b exp=%b", {zf, sf, of}, exp_flags());
    end
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_novalid%0d got=%b exp=0", k, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    fun = 4'd0;
    A = '0;
    B = '0;
    set_cc = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
